// File: rtl/pipe_pkg.sv
// Shared types and per-boundary constants for ready/valid pipeline stages.
//   occ_t          : stage occupancy (0..2 entries)
//   OCC_*          : named occupancy values
//   KILL_*         : payload kill masks applied to invalid entries at each stage boundary
package pipe_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    localparam int unsigned PAYLOAD_W_DEF = 72;
    localparam int unsigned CNT_W_DEF     = 16;

    // Kill masks assume the core's payload layout keeps side-effect enables in the low bits.
    localparam logic [PAYLOAD_W_DEF-1:0] KILL_NONE     = '0;
    localparam logic [PAYLOAD_W_DEF-1:0] KILL_MEMEX_WB = PAYLOAD_W_DEF'(72'h1); // regfile write enable
    localparam logic [PAYLOAD_W_DEF-1:0] KILL_EX_MEM   = PAYLOAD_W_DEF'(72'h3); // mem write + regfile we

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid flag, invalid tag and payload register.
// Ports:
//   clk, rst              : clock, async active-high reset (clears everything)
//   load                  : capture in_invalid/in_payload and set valid
//   clear                 : drop valid and tag (wins over load); payload kept
//   in_invalid, in_payload: data to capture
//   valid, invalid, payload: registered slot contents
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic         in_invalid,
    input  logic [W-1:0] in_payload,
    output logic         valid,
    output logic         invalid,
    output logic [W-1:0] payload
);

    // Slot register; clear has priority so flush can override a same-cycle load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            invalid <= 1'b0;
            payload <= '0;
        end else if (clear) begin
            valid   <= 1'b0;
            invalid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            invalid <= in_invalid;
            payload <= in_payload;
        end
    end

endmodule

// File: rtl/pipe_stage_rv.sv
// Generic ready/valid pipeline stage with kill mask, flush, optional skid slot
// and a saturating back-pressure counter.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   flush                             : drop held and incoming entries at next edge
//   up_valid/up_ready/up_invalid/up_payload : upstream handshake and entry
//   dn_valid/dn_ready/dn_invalid/dn_payload : downstream handshake and main-slot entry
//   occupancy                         : entries held (0..2, registered)
//   stall_cnt                         : cycles with dn_valid && !dn_ready, saturating
module pipe_stage_rv
    import pipe_pkg::*;
#(
    parameter int unsigned           PAYLOAD_W = PAYLOAD_W_DEF,
    parameter logic [PAYLOAD_W-1:0]  KILL_MASK = '0,
    parameter int unsigned           SKID      = 1,
    parameter int unsigned           CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic                 up_invalid,
    input  logic [PAYLOAD_W-1:0] up_payload,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic                 dn_invalid,
    output logic [PAYLOAD_W-1:0] dn_payload,
    output occ_t                 occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic                 acc;
    logic                 dep;
    logic [PAYLOAD_W-1:0] kill_payload;
    logic                 main_valid;
    logic                 main_load;
    logic                 main_clear;
    logic                 main_in_invalid;
    logic [PAYLOAD_W-1:0] main_in_payload;
    logic                 main_nxt;
    logic                 skid_nxt;

    assign acc          = up_valid && up_ready;
    assign dep          = main_valid && dn_ready;
    assign kill_payload = up_invalid ? (up_payload & ~KILL_MASK) : up_payload;
    assign dn_valid     = main_valid;

    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .clear      (main_clear),
        .in_invalid (main_in_invalid),
        .in_payload (main_in_payload),
        .valid      (main_valid),
        .invalid    (dn_invalid),
        .payload    (dn_payload)
    );

    generate
        if (SKID == 1) begin : g_skid
            logic                 skid_valid;
            logic                 skid_invalid;
            logic [PAYLOAD_W-1:0] skid_payload;
            logic                 skid_load;
            logic                 skid_clear;

            pipe_slot #(.W(PAYLOAD_W)) u_skid (
                .clk        (clk),
                .rst        (rst),
                .load       (skid_load),
                .clear      (skid_clear),
                .in_invalid (up_invalid),
                .in_payload (kill_payload),
                .valid      (skid_valid),
                .invalid    (skid_invalid),
                .payload    (skid_payload)
            );

            // Skid empty means room for one more entry even if main stalls.
            assign up_ready = !skid_valid;

            // Main refills from skid first to keep FIFO order; skid catches input when main is stuck.
            always_comb begin
                main_load       = 1'b0;
                main_in_invalid = up_invalid;
                main_in_payload = kill_payload;
                skid_load       = 1'b0;
                skid_clear      = flush;
                if (!flush) begin
                    if (!main_valid || dn_ready) begin
                        if (skid_valid) begin
                            main_load       = 1'b1;
                            main_in_invalid = skid_invalid;
                            main_in_payload = skid_payload;
                            skid_clear      = 1'b1;
                        end else if (acc) begin
                            main_load = 1'b1;
                        end
                    end else if (acc) begin
                        skid_load = 1'b1;
                    end
                end
                main_clear = flush || (dep && !main_load);
            end

            assign skid_nxt = skid_load || (skid_valid && !skid_clear);
        end else begin : g_noskid
            assign up_ready = !main_valid || dn_ready;

            always_comb begin
                main_load       = !flush && acc;
                main_in_invalid = up_invalid;
                main_in_payload = kill_payload;
                main_clear      = flush || (dep && !acc);
            end

            assign skid_nxt = 1'b0;
        end
    endgenerate

    assign main_nxt = main_load || (main_valid && !main_clear);

    // Occupancy tracks the slot valids as they will be after this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= OCC_EMPTY;
        end else begin
            occupancy <= occ_t'(main_nxt) + occ_t'(skid_nxt);
        end
    end

    // Back-pressure counter, saturating at all-ones; flush does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !dn_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
